fmap_writer: RTL and testbench

- Write side of the convolution window path. Upstream computes one result per K×K window position.
- This block collects those results in raster order into an OH×OW output feature-map buffer.
- It drives the expected window coordinates (oi, oj) back to the patch extractor.
- When the frame is complete, it presents the whole map with a valid/ready handshake.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/fmap_writer_if.sv | 48 ++++
 rtl/fmap_writer_raster_counter.sv | 63 ++++++
 rtl/fmap_writer.sv | 110 +++++++++++
 tb/tb_fmap_writer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN geometry helpers and write-side state encoding
//
// Contents:
//   out_dim(h, k, s, p) : output extent of a strided, padded K-wide window sweep
//   clog2_min1(v)       : bit width needed to index v items, never below 1
//   fm_state_e          : FILL (accepting samples) / HOLD (frame presented)

package cnn_pkg;

    // Same formula the patch extractor uses, so both ends agree on OH/OW.
    function automatic int out_dim(input int h, input int k, input int s, input int p);
        return (h + 2 * p - k) / s + 1;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fm_state_e;

endpackage

// File: rtl/fmap_writer_if.sv
// rtl/fmap_writer_if.sv - sample stream, window coordinates and frame handshake bundle
//
// Signals:
//   in_valid/in_data/in_ready : one convolution result per window position
//   oi/oj                     : window coordinates the writer expects next
//   fmap_valid/fmap/fmap_ready: completed OH x OW map, element (r,c) at [(r*OW+c)*D +: D]
//   frame_done                : one-cycle pulse when fmap_valid rises
// Modports:
//   slave  : the feature-map writer
//   master : the producer / consumer side

interface fmap_writer_if #(
    parameter int H = 5,
    parameter int W = 5,
    parameter int K = 3,
    parameter int S = 1,
    parameter int P = 1,
    parameter int D = 8
);
    import cnn_pkg::*;

    localparam int OH = out_dim(H, K, S, P);
    localparam int OW = out_dim(W, K, S, P);
    localparam int N  = OH * OW;
    localparam int IW = clog2_min1(OH);
    localparam int JW = clog2_min1(OW);

    logic             in_valid;
    logic [D-1:0]     in_data;
    logic             in_ready;
    logic [IW-1:0]    oi;
    logic [JW-1:0]    oj;
    logic             fmap_valid;
    logic [N*D-1:0]   fmap;
    logic             fmap_ready;
    logic             frame_done;

    modport slave (
        input  in_valid, in_data, fmap_ready,
        output in_ready, oi, oj, fmap_valid, fmap, frame_done
    );

    modport master (
        output in_valid, in_data, fmap_ready,
        input  in_ready, oi, oj, fmap_valid, fmap, frame_done
    );

endinterface

// File: rtl/fmap_writer_raster_counter.sv
// rtl/fmap_writer_raster_counter.sv - wrap-around 2-D raster (row, column) counter
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (counter -> 0,0)
//   clr_i         : synchronous restart to (0,0), wins over inc_i
//   inc_i         : advance one position in raster order
//   oi_o, oj_o    : current row / column
//   last_o        : current position is (ROWS-1, COLS-1)

module raster_counter #(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int IW   = 3,
    parameter int JW   = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [IW-1:0] oi_o,
    output logic [JW-1:0] oj_o,
    output logic          last_o
);

    logic [IW-1:0] oi_q, oi_d;
    logic [JW-1:0] oj_q, oj_d;
    logic          row_end;
    logic          col_end;

    assign row_end = (oi_q == IW'(ROWS - 1));
    assign col_end = (oj_q == JW'(COLS - 1));
    assign last_o  = row_end && col_end;
    assign oi_o    = oi_q;
    assign oj_o    = oj_q;

    always_comb begin
        oi_d = oi_q;
        oj_d = oj_q;
        if (clr_i) begin
            oi_d = '0;
            oj_d = '0;
        end else if (inc_i) begin
            if (col_end) begin
                oj_d = '0;
                // After the final position both coordinates land back on 0.
                oi_d = row_end ? '0 : oi_q + IW'(1);
            end else begin
                oj_d = oj_q + JW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oi_q <= '0;
            oj_q <= '0;
        end else begin
            oi_q <= oi_d;
            oj_q <= oj_d;
        end
    end

endmodule

// File: rtl/fmap_writer.sv
// rtl/fmap_writer.sv - collects raster-ordered window results into an output feature map
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (state FILL, counters 0, fmap zeroed)
//   clr  : synchronous frame abort; fmap contents kept, same-cycle sample dropped
//   bus  : fmap_writer_if.slave (sample stream in, coordinates out, frame handshake out)

module fmap_writer
    import cnn_pkg::*;
#(
    parameter int H = 5,
    parameter int W = 5,
    parameter int K = 3,
    parameter int S = 1,
    parameter int P = 1,
    parameter int D = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    fmap_writer_if.slave  bus
);

    localparam int OH = out_dim(H, K, S, P);
    localparam int OW = out_dim(W, K, S, P);
    localparam int N  = OH * OW;
    localparam int IW = clog2_min1(OH);
    localparam int JW = clog2_min1(OW);

    if (H + 2 * P < K || W + 2 * P < K) begin : g_bad_geometry
        $error("fmap_writer: window K larger than padded image");
    end

    fm_state_e      state_q, state_d;
    logic [N*D-1:0] fmap_q, fmap_d;
    logic           frame_done_q, frame_done_d;
    logic           accept;
    logic           last;
    logic [IW-1:0]  oi;
    logic [JW-1:0]  oj;
    logic [31:0]    widx;

    // A sample arriving alongside clr is dropped, so clr gates acceptance.
    assign bus.in_ready = (state_q == FILL) && !rst;
    assign accept       = bus.in_valid && bus.in_ready && !clr;

    raster_counter #(
        .ROWS (OH),
        .COLS (OW),
        .IW   (IW),
        .JW   (JW)
    ) u_raster (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (clr),
        .inc_i  (accept),
        .oi_o   (oi),
        .oj_o   (oj),
        .last_o (last)
    );

    assign widx = 32'(oi) * 32'(OW) + 32'(oj);

    always_comb begin
        state_d      = state_q;
        fmap_d       = fmap_q;
        frame_done_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    fmap_d[widx*D +: D] = bus.in_data;
                    if (last) begin
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.fmap_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (clr) begin
            state_d      = FILL;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            fmap_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fmap_q       <= fmap_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.oi         = oi;
    assign bus.oj         = oj;
    assign bus.fmap       = fmap_q;
    assign bus.fmap_valid = (state_q == HOLD);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fmap_writer.sv
// tb/tb_fmap_writer.sv - directed bench for fmap_writer at three geometries

module tb_fmap_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic a_rst, a_clr, b_rst, b_clr, c_rst, c_clr;
    logic [7:0] exp_a [25];
    logic [7:0] exp_b [25];

    fmap_writer_if #(.H(5), .W(5), .K(3), .S(1), .P(1), .D(8)) a_if ();
    fmap_writer_if #(.H(5), .W(5), .K(3), .S(2), .P(1), .D(8)) b_if ();
    fmap_writer_if #(.H(3), .W(3), .K(3), .S(1), .P(0), .D(8)) c_if ();

    fmap_writer #(.H(5), .W(5), .K(3), .S(1), .P(1), .D(8)) u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .bus(a_if));
    fmap_writer #(.H(5), .W(5), .K(3), .S(2), .P(1), .D(8)) u_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .bus(b_if));
    fmap_writer #(.H(3), .W(3), .K(3), .S(1), .P(0), .D(8)) u_c (
        .clk(clk), .rst(c_rst), .clr(c_clr), .bus(c_if));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] pack(input logic [7:0] arr [25], input int n);
        logic [255:0] v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = arr[i];
        return v;
    endfunction

    // Back-to-back samples base+k into DUT A, checking the expected coordinates each cycle.
    task automatic a_feed(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = 8'(base + k);
            check("a_oi", a_if.oi, k / 5);
            check("a_oj", a_if.oj, k % 5);
            check("a_in_ready", a_if.in_ready, 1);
            tick();
            exp_a[k] = 8'(base + k);
        end
        a_if.in_valid = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;
        logic acc;

        a_if.in_valid = 0; a_if.in_data = 0; a_if.fmap_ready = 0;
        b_if.in_valid = 0; b_if.in_data = 0; b_if.fmap_ready = 0;
        c_if.in_valid = 0; c_if.in_data = 0; c_if.fmap_ready = 0;
        a_clr = 0; b_clr = 0; c_clr = 0;
        a_rst = 1; b_rst = 1; c_rst = 1;
        for (int i = 0; i < 25; i++) begin exp_a[i] = 0; exp_b[i] = 0; end

        tick(); tick();
        check("rst_in_ready", a_if.in_ready, 0);
        check("rst_fmap_valid", a_if.fmap_valid, 0);
        check("rst_frame_done", a_if.frame_done, 0);
        check("rst_fmap", a_if.fmap, 0);
        check("rst_oi", a_if.oi, 0);
        a_rst = 0; b_rst = 0; c_rst = 0;
        tick();
        check("post_rst_in_ready", a_if.in_ready, 1);

        // Frame 1: 25 back-to-back samples, value == index.
        a_feed(25, 0);
        check("f1_frame_done", a_if.frame_done, 1);
        check("f1_fmap_valid", a_if.fmap_valid, 1);
        check("f1_in_ready", a_if.in_ready, 0);
        check("f1_oi_end", a_if.oi, 0);
        check("f1_oj_end", a_if.oj, 0);
        check("f1_fmap", a_if.fmap, pack(exp_a, 25));
        a_if.in_valid = 1; a_if.in_data = 8'hEE;
        tick();
        a_if.in_valid = 0;
        check("f1_done_once", a_if.frame_done, 0);
        check("f1_26th_ignored", a_if.fmap, pack(exp_a, 25));

        // Readout: consumer stalls, then takes the frame.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_fmap", a_if.fmap, pack(exp_a, 25));
            check("hold_valid", a_if.fmap_valid, 1);
        end
        a_if.fmap_ready = 1;
        tick();
        a_if.fmap_ready = 0;
        check("rd_valid_low", a_if.fmap_valid, 0);
        check("rd_oi", a_if.oi, 0);
        check("rd_oj", a_if.oj, 0);
        check("rd_retained", a_if.fmap, pack(exp_a, 25));
        tick();
        check("rd_in_ready", a_if.in_ready, 1);

        // Abort after 12 samples; the 0xFF presented with clr must be dropped.
        a_feed(12, 8'h40);
        a_if.in_valid = 1; a_if.in_data = 8'hFF; a_clr = 1;
        tick();
        a_if.in_valid = 0; a_clr = 0;
        check("clr_oi", a_if.oi, 0);
        check("clr_oj", a_if.oj, 0);
        check("clr_no_ff", a_if.fmap, pack(exp_a, 25));
        a_feed(25, 8'h80);
        check("f2_frame_done", a_if.frame_done, 1);
        check("f2_fmap", a_if.fmap, pack(exp_a, 25));

        // clr together with the readout handshake in HOLD.
        a_clr = 1; a_if.fmap_ready = 1;
        tick();
        a_clr = 0; a_if.fmap_ready = 0;
        check("clr_hs_valid", a_if.fmap_valid, 0);
        check("clr_hs_in_ready", a_if.in_ready, 1);
        check("clr_hs_fmap", a_if.fmap, pack(exp_a, 25));

        // Reset mid-frame, with fmap_ready high in FILL having no effect.
        a_if.fmap_ready = 1;
        a_feed(7, 8'h10);
        a_if.fmap_ready = 0;
        check("pre_rst_oi", a_if.oi, 1);
        check("pre_rst_oj", a_if.oj, 2);
        a_rst = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid_rst_in_ready", a_if.in_ready, 0);
            check("mid_rst_fmap", a_if.fmap, 0);
            check("mid_rst_valid", a_if.fmap_valid, 0);
            check("mid_rst_done", a_if.frame_done, 0);
        end
        a_rst = 0;
        tick();
        check("after_rst_in_ready", a_if.in_ready, 1);
        check("after_rst_oi", a_if.oi, 0);
        check("after_rst_oj", a_if.oj, 0);

        // Stride 2: 3x3 map, samples with random gaps.
        k = 0;
        cyc = 0;
        while (k < 9 && cyc < 300) begin
            b_if.in_valid = 1'($urandom_range(0, 1));
            b_if.in_data  = 8'(8'hA0 + k);
            check("b_oi", b_if.oi, k / 3);
            check("b_oj", b_if.oj, k % 3);
            check("b_valid_early", b_if.fmap_valid, 0);
            acc = b_if.in_valid && b_if.in_ready;
            tick();
            if (acc) begin
                exp_b[k] = 8'(8'hA0 + k);
                k++;
            end
            cyc++;
        end
        b_if.in_valid = 0;
        check("b_count", k, 9);
        check("b_fmap_valid", b_if.fmap_valid, 1);
        check("b_frame_done", b_if.frame_done, 1);
        check("b_fmap", b_if.fmap, pack(exp_b, 9));
        tick();
        check("b_done_once", b_if.frame_done, 0);

        // Degenerate 1x1 map.
        check("c_in_ready", c_if.in_ready, 1);
        c_if.in_valid = 1; c_if.in_data = 8'h5A;
        tick();
        c_if.in_valid = 0;
        check("c_fmap_valid", c_if.fmap_valid, 1);
        check("c_frame_done", c_if.frame_done, 1);
        check("c_fmap", c_if.fmap, 8'h5A);
        check("c_in_ready_hold", c_if.in_ready, 0);
        tick();
        check("c_done_once", c_if.frame_done, 0);
        check("c_still_valid", c_if.fmap_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
